// File: rtl/bcd_counter_multi.sv
// Multi-decade packed-BCD up/down counter with clear, validated parallel load,
// and wrap/saturate behaviour at the limits. Carries use per-digit lookahead.
module bcd_counter_multi #(
    parameter int DIGITS = 3,
    parameter bit WRAP   = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  inc,
    input  logic                  dec,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    output logic [4*DIGITS-1:0]   valor,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  load_error,
    output logic                  zero
);

    localparam int W = 4 * DIGITS;

    logic [W-1:0]      count_q;
    logic [W-1:0]      guarded;
    logic [W-1:0]      inc_next;
    logic [W-1:0]      dec_next;
    logic [W-1:0]      max_value;
    logic [DIGITS-1:0] is_nine;
    logic [DIGITS-1:0] is_zero;
    logic [DIGITS-1:0] load_digit_ok;
    logic [DIGITS-1:0] carry;
    logic [DIGITS-1:0] borrow;
    logic              at_max;
    logic              at_zero;
    logic              load_ok;
    logic              step_up;
    logic              step_down;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_digit
            logic [3:0] d;
            // A forced non-BCD nibble is treated as 9 so arithmetic stays in range.
            assign d = (count_q[4*g +: 4] > 4'd9) ? 4'd9 : count_q[4*g +: 4];
            assign guarded[4*g +: 4]  = d;
            assign is_nine[g]         = (d == 4'd9);
            assign is_zero[g]         = (d == 4'd0);
            assign load_digit_ok[g]   = (load_value[4*g +: 4] <= 4'd9);
            assign max_value[4*g +: 4] = 4'd9;

            // Lookahead: each digit sees the AND of all lower digits directly.
            if (g == 0) begin : g_first
                assign carry[g]  = 1'b1;
                assign borrow[g] = 1'b1;
            end else begin : g_rest
                assign carry[g]  = &is_nine[g-1:0];
                assign borrow[g] = &is_zero[g-1:0];
            end

            assign inc_next[4*g +: 4] = !carry[g]  ? d : (is_nine[g] ? 4'd0 : d + 4'd1);
            assign dec_next[4*g +: 4] = !borrow[g] ? d : (is_zero[g] ? 4'd9 : d - 4'd1);
        end
    endgenerate

    assign at_max    = &is_nine;
    assign at_zero   = &is_zero;
    assign load_ok   = &load_digit_ok;
    assign step_up   = inc && !dec;
    assign step_down = dec && !inc;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count_q    <= '0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            load_error <= 1'b0;
        end else begin
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            load_error <= 1'b0;
            if (load) begin
                if (load_ok) begin
                    count_q <= load_value;
                end else begin
                    load_error <= 1'b1;
                end
            end else if (step_up) begin
                if (at_max) begin
                    overflow <= 1'b1;
                    count_q  <= WRAP ? '0 : max_value;
                end else begin
                    count_q <= inc_next;
                end
            end else if (step_down) begin
                if (at_zero) begin
                    underflow <= 1'b1;
                    count_q   <= WRAP ? max_value : '0;
                end else begin
                    count_q <= dec_next;
                end
            end
        end
    end

    assign valor = count_q;
    assign zero  = (count_q == '0);

endmodule

// File: tb/tb_bcd_counter_multi.sv
// Directed bench for bcd_counter_multi: a wrapping and a saturating instance
// (DIGITS=3) share one stimulus stream; each task checks the instance it targets.
module tb_bcd_counter_multi;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic        inc   = 1'b0;
    logic        dec   = 1'b0;
    logic        load  = 1'b0;
    logic [11:0] load_value = 12'h000;

    logic [11:0] w_valor, s_valor;
    logic        w_ov, w_uf, w_le, w_zero;
    logic        s_ov, s_uf, s_le, s_zero;
    logic [15:0] w_stat, s_stat;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    bcd_counter_multi #(.DIGITS(3), .WRAP(1'b1)) dut_wrap (
        .clock(clock), .reset(reset), .clear(clear), .inc(inc), .dec(dec),
        .load(load), .load_value(load_value), .valor(w_valor),
        .overflow(w_ov), .underflow(w_uf), .load_error(w_le), .zero(w_zero)
    );

    bcd_counter_multi #(.DIGITS(3), .WRAP(1'b0)) dut_sat (
        .clock(clock), .reset(reset), .clear(clear), .inc(inc), .dec(dec),
        .load(load), .load_value(load_value), .valor(s_valor),
        .overflow(s_ov), .underflow(s_uf), .load_error(s_le), .zero(s_zero)
    );

    // Status word: {valor, overflow, underflow, load_error, zero}
    assign w_stat = {w_valor, w_ov, w_uf, w_le, w_zero};
    assign s_stat = {s_valor, s_ov, s_uf, s_le, s_zero};

    // Apply one cycle of inputs and sample 1 time unit after the edge.
    task automatic drive(input logic r, input logic c, input logic l,
                         input logic i, input logic d, input logic [11:0] lv);
        reset = r; clear = c; load = l; inc = i; dec = d; load_value = lv;
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        vectors++;
        if (w_stat !== {12'h000, 4'b0001}) begin
            miscompares++;
            $display("FAIL reset_wrap got=%h exp=%h", w_stat, {12'h000, 4'b0001});
        end
        vectors++;
        if (s_stat !== {12'h000, 4'b0001}) begin
            miscompares++;
            $display("FAIL reset_sat got=%h exp=%h", s_stat, {12'h000, 4'b0001});
        end
    endtask

    task automatic test_inc_sequence();
        logic [11:0] seq [12];
        seq = '{12'h001, 12'h002, 12'h003, 12'h004, 12'h005, 12'h006,
                12'h007, 12'h008, 12'h009, 12'h010, 12'h011, 12'h012};
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        for (int i = 0; i < 12; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000);
            vectors++;
            if (w_stat !== {seq[i], 4'b0000}) begin
                miscompares++;
                $display("FAIL inc_seq[%0d] got=%h exp=%h", i, w_stat, {seq[i], 4'b0000});
            end
        end
    endtask

    task automatic test_wrap_overflow();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h998);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000);
        vectors++;
        if (w_stat !== {12'h999, 4'b0000}) begin
            miscompares++;
            $display("FAIL wrap_to_999 got=%h exp=%h", w_stat, {12'h999, 4'b0000});
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000);
        vectors++;
        if (w_stat !== {12'h000, 4'b1001}) begin
            miscompares++;
            $display("FAIL wrap_overflow got=%h exp=%h", w_stat, {12'h000, 4'b1001});
        end
        idle();
        vectors++;
        if (w_stat !== {12'h000, 4'b0001}) begin
            miscompares++;
            $display("FAIL wrap_pulse_end got=%h exp=%h", w_stat, {12'h000, 4'b0001});
        end
    endtask

    task automatic test_saturate();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h999);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000);
            vectors++;
            if (s_stat !== {12'h999, 4'b1000}) begin
                miscompares++;
                $display("FAIL sat_hold[%0d] got=%h exp=%h", i, s_stat, {12'h999, 4'b1000});
            end
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000);
        vectors++;
        if (s_stat !== {12'h998, 4'b0000}) begin
            miscompares++;
            $display("FAIL sat_dec got=%h exp=%h", s_stat, {12'h998, 4'b0000});
        end
    endtask

    task automatic test_underflow_borrow();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000);
        vectors++;
        if (w_stat !== {12'h999, 4'b0100}) begin
            miscompares++;
            $display("FAIL wrap_underflow got=%h exp=%h", w_stat, {12'h999, 4'b0100});
        end
        vectors++;
        if (s_stat !== {12'h000, 4'b0101}) begin
            miscompares++;
            $display("FAIL sat_underflow got=%h exp=%h", s_stat, {12'h000, 4'b0101});
        end
        idle();
        vectors++;
        if (w_stat !== {12'h999, 4'b0000}) begin
            miscompares++;
            $display("FAIL underflow_pulse_end got=%h exp=%h", w_stat, {12'h999, 4'b0000});
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h100);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000);
        vectors++;
        if (w_stat !== {12'h099, 4'b0000}) begin
            miscompares++;
            $display("FAIL borrow_100 got=%h exp=%h", w_stat, {12'h099, 4'b0000});
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h010);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000);
        vectors++;
        if (w_stat !== {12'h009, 4'b0000}) begin
            miscompares++;
            $display("FAIL borrow_010 got=%h exp=%h", w_stat, {12'h009, 4'b0000});
        end
    endtask

    task automatic test_load();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h250);
        vectors++;
        if (w_stat !== {12'h250, 4'b0000}) begin
            miscompares++;
            $display("FAIL load_250 got=%h exp=%h", w_stat, {12'h250, 4'b0000});
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h1A3);
        vectors++;
        if (w_stat !== {12'h250, 4'b0010}) begin
            miscompares++;
            $display("FAIL load_reject got=%h exp=%h", w_stat, {12'h250, 4'b0010});
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'hF00);
        vectors++;
        if (s_stat !== {12'h250, 4'b0010}) begin
            miscompares++;
            $display("FAIL load_reject_top got=%h exp=%h", s_stat, {12'h250, 4'b0010});
        end
        idle();
        vectors++;
        if (w_stat !== {12'h250, 4'b0000}) begin
            miscompares++;
            $display("FAIL load_err_end got=%h exp=%h", w_stat, {12'h250, 4'b0000});
        end
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 12'h473);
        vectors++;
        if (w_stat !== {12'h473, 4'b0000}) begin
            miscompares++;
            $display("FAIL load_beats_inc got=%h exp=%h", w_stat, {12'h473, 4'b0000});
        end
    endtask

    task automatic test_inc_dec_both();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000);
        vectors++;
        if (w_stat !== {12'h473, 4'b0000}) begin
            miscompares++;
            $display("FAIL both_mid got=%h exp=%h", w_stat, {12'h473, 4'b0000});
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h999);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000);
        vectors++;
        if (w_stat !== {12'h999, 4'b0000}) begin
            miscompares++;
            $display("FAIL both_at_max got=%h exp=%h", w_stat, {12'h999, 4'b0000});
        end
    endtask

    task automatic test_clear_priority();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h500);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000);
        vectors++;
        if (w_stat !== {12'h501, 4'b0000}) begin
            miscompares++;
            $display("FAIL pre_clear got=%h exp=%h", w_stat, {12'h501, 4'b0000});
        end
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 12'h473);
        vectors++;
        if (w_stat !== {12'h000, 4'b0001}) begin
            miscompares++;
            $display("FAIL clear_beats_load got=%h exp=%h", w_stat, {12'h000, 4'b0001});
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h999);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000);
        vectors++;
        if (w_stat !== {12'h000, 4'b1001}) begin
            miscompares++;
            $display("FAIL pending_ov got=%h exp=%h", w_stat, {12'h000, 4'b1001});
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000);
        vectors++;
        if (w_stat !== {12'h000, 4'b0001}) begin
            miscompares++;
            $display("FAIL clear_kills_ov got=%h exp=%h", w_stat, {12'h000, 4'b0001});
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000);
        vectors++;
        if (w_stat !== {12'h998, 4'b0000}) begin
            miscompares++;
            $display("FAIL pre_reset got=%h exp=%h", w_stat, {12'h998, 4'b0000});
        end
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 12'h473);
        vectors++;
        if (w_stat !== {12'h000, 4'b0001}) begin
            miscompares++;
            $display("FAIL all_mid_count got=%h exp=%h", w_stat, {12'h000, 4'b0001});
        end
        vectors++;
        if (s_stat !== {12'h000, 4'b0001}) begin
            miscompares++;
            $display("FAIL all_mid_count_sat got=%h exp=%h", s_stat, {12'h000, 4'b0001});
        end
    endtask

    initial begin
        test_reset();
        test_inc_sequence();
        test_wrap_overflow();
        test_saturate();
        test_underflow_borrow();
        test_load();
        test_inc_dec_both();
        test_clear_priority();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
